// File: rtl/apb_reg_slave_if.sv
// rtl/apb_reg_slave_if.sv - APB bus bundle between the bridge (master) and apb_reg_slave (slave)
//   psel_i/penable_i/pwrite_i/paddr_i/pprot_i/pwdata_i/pstrb_i : driven by the master
//   pready_o/prdata_o/pslverr_o                                : driven by the slave
interface apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel_i;
    logic                    penable_i;
    logic                    pwrite_i;
    logic [ADDR_WIDTH-1:0]   paddr_i;
    logic [2:0]              pprot_i;
    logic [DATA_WIDTH-1:0]   pwdata_i;
    logic [DATA_WIDTH/8-1:0] pstrb_i;
    logic                    pready_o;
    logic [DATA_WIDTH-1:0]   prdata_o;
    logic                    pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pprot_i, pwdata_i, pstrb_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pprot_i, pwdata_i, pstrb_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register slave: CTRL regs, STATUS, W1C EVT with IRQ_EN, ID, wait states
//   PCLKMST_PCLK : clock
//   PRSTnMS_PCLK : asynchronous active-low reset
//   bus          : APB slave port (apb_reg_slave_if.slave)
//   ctrl_o       : flattened CTRL registers, reg n at [32n+31:32n]
//   status_i     : live status, returned at 0x40
//   event_i      : per-bit event set pulses into EVT (0x44)
//   irq_o        : registered |(EVT & IRQ_EN)
//   Optional macro APB_REG_PROT_CHECK_EN: unprivileged accesses (pprot[0]=0) get pslverr.
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                           PCLKMST_PCLK,
    input  logic                           PRSTnMS_PCLK,
    apb_reg_slave_if.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
    input  logic [DATA_WIDTH-1:0]          status_i,
    input  logic [DATA_WIDTH-1:0]          event_i,
    output logic                           irq_o
);
    localparam logic [7:0] OFF_STATUS = 8'h40;
    localparam logic [7:0] OFF_EVT    = 8'h44;
    localparam logic [7:0] OFF_IRQ_EN = 8'h48;
    localparam logic [7:0] OFF_ID     = 8'h4C;
    localparam int         CTRL_END   = 4 * NUM_REGS;
    localparam logic [2:0] WS         = 3'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  err_q;
    logic                  write_q;
    logic [7:0]            off_q;
    logic [DATA_WIDTH-1:0] ctrl_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] evt_q, evt_d;
    logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d;

    logic [7:0]            off;
    logic                  setup;
    logic                  setup_err;
    logic                  done;
    logic                  commit;
    logic                  ctrl_hit_q;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] evt_clr;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  unused_bits;

    assign off         = bus.paddr_i[7:0];
    assign setup       = bus.psel_i && !bus.penable_i;
    assign unused_bits = ^{bus.paddr_i[ADDR_WIDTH-1:8], bus.pprot_i};

    // Error classification happens once, in the setup phase, and is held for the access.
    always_comb begin
        setup_err = 1'b0;
        if (off[1:0] != 2'b00)
            setup_err = 1'b1;
        else if (int'(off) < CTRL_END)
            setup_err = 1'b0;
        else if (off == OFF_STATUS || off == OFF_ID)
            setup_err = bus.pwrite_i;
        else if (off == OFF_EVT || off == OFF_IRQ_EN)
            setup_err = 1'b0;
        else
            setup_err = 1'b1;
`ifdef APB_REG_PROT_CHECK_EN
        if (!bus.pprot_i[0])
            setup_err = 1'b1;
`endif
    end

    assign done       = (state_q == ACCESS) && bus.psel_i && bus.penable_i && (cnt_q == WS);
    assign commit     = done && !err_q && write_q;
    assign ctrl_hit_q = int'(off_q) < CTRL_END;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = 3'd0;
                end
            end
            ACCESS: begin
                if (!bus.psel_i)
                    state_d = IDLE;          // master abandoned the transfer
                else if (bus.penable_i) begin
                    if (done)
                        state_d = IDLE;      // a back-to-back setup is picked up from IDLE next cycle
                    else if (cnt_q < WS)
                        cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wmask = '0;
        for (int i = 0; i < DATA_WIDTH/8; i++)
            wmask[8*i +: 8] = {8{bus.pstrb_i[i]}};
    end

    // Set wins over clear: clear first, then OR in this cycle's events.
    always_comb begin
        evt_clr  = (commit && off_q == OFF_EVT) ? (bus.pwdata_i & wmask) : '0;
        evt_d    = (evt_q & ~evt_clr) | event_i;
        irq_en_d = irq_en_q;
        if (commit && off_q == OFF_IRQ_EN)
            irq_en_d = (irq_en_q & ~wmask) | (bus.pwdata_i & wmask);
    end

    always_ff @(posedge PCLKMST_PCLK or negedge PRSTnMS_PCLK) begin
        if (!PRSTnMS_PCLK) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            off_q    <= 8'd0;
            evt_q    <= '0;
            irq_en_q <= '0;
            irq_o    <= 1'b0;
            for (int n = 0; n < NUM_REGS; n++)
                ctrl_q[n] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
            irq_en_q <= irq_en_d;
            irq_o    <= |(evt_d & irq_en_d);
            if (state_q == IDLE && setup) begin
                err_q   <= setup_err;
                write_q <= bus.pwrite_i;
                off_q   <= off;
            end
            for (int n = 0; n < NUM_REGS; n++)
                if (commit && ctrl_hit_q && off_q[5:2] == 4'(n))
                    ctrl_q[n] <= (ctrl_q[n] & ~wmask) | (bus.pwdata_i & wmask);
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (ctrl_hit_q) begin
            for (int n = 0; n < NUM_REGS; n++)
                if (off_q[5:2] == 4'(n))
                    rdata_mux = ctrl_q[n];
        end else begin
            case (off_q)
                OFF_STATUS: rdata_mux = status_i;
                OFF_EVT:    rdata_mux = evt_q;
                OFF_IRQ_EN: rdata_mux = irq_en_q;
                OFF_ID:     rdata_mux = ID_VALUE;
                default:    rdata_mux = '0;
            endcase
        end
    end

    assign bus.pready_o  = done;
    assign bus.pslverr_o = done && err_q;
    assign bus.prdata_o  = (done && !err_q && !write_q) ? rdata_mux : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - randomized self-checking bench for apb_reg_slave against a register-map model
module tb_apb_reg_slave;
    localparam logic [31:0] ID  = 32'hA9B0_0001;
    localparam logic [31:0] WIN = 32'h0013_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  status, evt_in, status0, evt_in0;
    logic [255:0] ctrl, ctrl0;
    logic         irq, irq0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_ctrl [8];
    logic [31:0] m_evt, m_irq_en;

    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

    apb_reg_slave #(.WAIT_STATES(1)) u_dut (
        .PCLKMST_PCLK(clk), .PRSTnMS_PCLK(rst_n), .bus(bus),
        .ctrl_o(ctrl), .status_i(status), .event_i(evt_in), .irq_o(irq)
    );

    apb_reg_slave #(.WAIT_STATES(0)) u_dut0 (
        .PCLKMST_PCLK(clk), .PRSTnMS_PCLK(rst_n), .bus(bus0),
        .ctrl_o(ctrl0), .status_i(status0), .event_i(evt_in0), .irq_o(irq0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic bit exp_err(input bit wr, input logic [7:0] off, input logic [2:0] prot);
        bit mapped;
        mapped = (off % 4 == 0) && (off < 8'h20 || off == 8'h40 || off == 8'h44 || off == 8'h48 || off == 8'h4C);
        if (!mapped) return 1'b1;
        if (wr && (off == 8'h40 || off == 8'h4C)) return 1'b1;
`ifdef APB_REG_PROT_CHECK_EN
        if (prot[0] == 1'b0) return 1'b1;
`else
        if (prot === 3'bxxx) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        if (off < 8'h20) return m_ctrl[off / 4];
        case (off)
            8'h40:   return status;
            8'h44:   return m_evt;
            8'h48:   return m_irq_en;
            8'h4C:   return ID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] m;
        m = strb_mask(strb);
        if (off < 8'h20)      m_ctrl[off / 4] = (m_ctrl[off / 4] & ~m) | (d & m);
        else if (off == 8'h44) m_evt = m_evt & ~(d & m);
        else if (off == 8'h48) m_irq_en = (m_irq_en & ~m) | (d & m);
    endtask

    // One APB transfer on the WAIT_STATES=1 instance. ev is driven onto event_i
    // during the completion cycle only.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] strb, input logic [2:0] prot, input logic [31:0] ev,
                            output logic [31:0] rdata, output logic err, output int cycles);
        bit got;
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
        bus.paddr_i = addr; bus.pwdata_i = d; bus.pstrb_i = strb; bus.pprot_i = prot;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        cycles = 0; got = 1'b0; rdata = '0; err = 1'b0;
        while (!got && cycles < 16) begin
            @(negedge clk);
            cycles++;
            if (bus.pready_o) begin
                rdata = bus.prdata_o; err = bus.pslverr_o; got = 1'b1;
                evt_in = ev;
            end else begin
                check("wait_prdata", bus.prdata_o, 32'h0);
                @(posedge clk); #1;
            end
        end
        if (!got) check("pready_timeout", 32'(got), 32'h1);
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; evt_in = '0;
    endtask

    task automatic do_xfer(input string tag, input bit wr, input logic [7:0] off, input logic [31:0] d,
                           input logic [3:0] strb, input logic [2:0] prot, input logic [31:0] ev);
        logic [31:0] rdata, exp_rd;
        logic err;
        int cycles;
        bit e;
        e = exp_err(wr, off, prot);
        exp_rd = (e || wr) ? 32'h0 : model_read(off);
        apb_xfer(wr, WIN | {24'h0, off}, d, strb, prot, ev, rdata, err, cycles);
        check({tag, "_cycles"}, 32'(cycles), 32'd2);
        check({tag, "_pslverr"}, 32'(err), 32'(e));
        check({tag, "_prdata"}, rdata, exp_rd);
        if (wr && !e) model_write(off, d, strb);
        m_evt = m_evt | ev;
        if (off < 8'h20) check({tag, "_ctrl_o"}, ctrl[(off / 4) * 32 +: 32], m_ctrl[off / 4]);
        check({tag, "_irq"}, 32'(irq), 32'(|(m_evt & m_irq_en)));
    endtask

    initial begin
        logic [7:0]  off;
        logic [31:0] d;
        int r;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = 0;
        bus.pwdata_i = 0; bus.pstrb_i = 0; bus.pprot_i = 0;
        bus0.psel_i = 0; bus0.penable_i = 0; bus0.pwrite_i = 0; bus0.paddr_i = 0;
        bus0.pwdata_i = 0; bus0.pstrb_i = 0; bus0.pprot_i = 0;
        status = 32'h5A5A_0F0F; evt_in = 0; status0 = 0; evt_in0 = 0;
        for (int i = 0; i < 8; i++) m_ctrl[i] = 0;
        m_evt = 0; m_irq_en = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 32'(bus.pready_o), 32'h0);
        check("rst_prdata", bus.prdata_o, 32'h0);
        check("rst_pslverr", 32'(bus.pslverr_o), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ctrl1", ctrl[63:32], 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // directed register-map checks
        do_xfer("wr_ctrl1", 1, 8'h04, 32'h1234_5678, 4'hF, 3'b001, 0);
        check("ctrl1_full", ctrl[63:32], 32'h1234_5678);
        do_xfer("rd_ctrl1", 0, 8'h04, 0, 4'hF, 3'b001, 0);
        do_xfer("wr_ctrl1_b1", 1, 8'h04, 32'hFFFF_FFFF, 4'b0010, 3'b001, 0);
        check("ctrl1_strb", ctrl[63:32], 32'h1234_FF78);
        do_xfer("rd_id", 0, 8'h4C, 0, 4'hF, 3'b001, 0);
        do_xfer("wr_id", 1, 8'h4C, 32'hDEAD_BEEF, 4'hF, 3'b001, 0);
        do_xfer("rd_id2", 0, 8'h4C, 0, 4'hF, 3'b001, 0);
        do_xfer("rd_0x50", 0, 8'h50, 0, 4'hF, 3'b001, 0);
        do_xfer("rd_0x06", 0, 8'h06, 0, 4'hF, 3'b001, 0);
        do_xfer("wr_status", 1, 8'h40, 32'h1, 4'hF, 3'b001, 0);
        do_xfer("rd_status", 0, 8'h40, 0, 4'hF, 3'b001, 0);

        // events and interrupt
        do_xfer("wr_irq_en", 1, 8'h48, 32'h1, 4'hF, 3'b001, 0);
        @(posedge clk); #1 evt_in = 32'h1;
        @(negedge clk);
        check("irq_before_evt", 32'(irq), 32'h0);
        @(posedge clk); #1 evt_in = 32'h0;
        m_evt = m_evt | 32'h1;
        check("irq_after_evt", 32'(irq), 32'h1);
        do_xfer("w1c_with_evt", 1, 8'h44, 32'h1, 4'hF, 3'b001, 32'h1);
        check("evt0_kept", 32'(irq), 32'h1);
        do_xfer("rd_evt", 0, 8'h44, 0, 4'hF, 3'b001, 0);
        do_xfer("w1c_clear", 1, 8'h44, 32'h1, 4'hF, 3'b001, 0);
        check("irq_cleared", 32'(irq), 32'h0);

        // back-to-back write then read, zero wait states
        @(posedge clk); #1;
        bus0.psel_i = 1; bus0.penable_i = 0; bus0.pwrite_i = 1;
        bus0.paddr_i = WIN | 32'h08; bus0.pwdata_i = 32'hC0DE_1234; bus0.pstrb_i = 4'hF; bus0.pprot_i = 3'b001;
        @(posedge clk); #1 bus0.penable_i = 1;
        @(negedge clk);
        check("b2b_wr_pready", 32'(bus0.pready_o), 32'h1);
        check("b2b_wr_pslverr", 32'(bus0.pslverr_o), 32'h0);
        @(posedge clk); #1;
        bus0.penable_i = 0; bus0.pwrite_i = 0;
        @(negedge clk);
        check("b2b_setup_pready", 32'(bus0.pready_o), 32'h0);
        check("b2b_ctrl2", ctrl0[95:64], 32'hC0DE_1234);
        @(posedge clk); #1 bus0.penable_i = 1;
        @(negedge clk);
        check("b2b_rd_pready", 32'(bus0.pready_o), 32'h1);
        check("b2b_rd_prdata", bus0.prdata_o, 32'hC0DE_1234);
        @(posedge clk); #1 bus0.psel_i = 0; bus0.penable_i = 0;

`ifdef APB_REG_PROT_CHECK_EN
        do_xfer("prot_wr", 1, 8'h00, 32'h7777_7777, 4'hF, 3'b000, 0);
        check("prot_no_update", ctrl[31:0], m_ctrl[0]);
`endif

        // randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      off = 8'($urandom_range(0, 19) * 4);
            else if (r < 8) off = 8'($urandom_range(20, 63) * 4);
            else            off = 8'($urandom_range(0, 255));
            d = $urandom;
            status = $urandom;
`ifdef APB_REG_PROT_CHECK_EN
            do_xfer("rnd", 1'($urandom_range(0, 1)), off, d, 4'($urandom), 3'($urandom),
                    ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0);
`else
            do_xfer("rnd", 1'($urandom_range(0, 1)), off, d, 4'($urandom), 3'($urandom),
                    ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0);
`endif
        end

        // reset during the access phase of a write to CTRL0
        do_xfer("pre_rst_wr", 1, 8'h00, 32'hCAFE_0001, 4'hF, 3'b001, 0);
        @(posedge clk); #1;
        bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = 1;
        bus.paddr_i = WIN; bus.pwdata_i = 32'h0BAD_F00D; bus.pstrb_i = 4'hF; bus.pprot_i = 3'b001;
        @(posedge clk); #1 bus.penable_i = 1;
        @(negedge clk);
        check("mid_rst_wait", 32'(bus.pready_o), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pready", 32'(bus.pready_o), 32'h0);
        check("mid_rst_ctrl0", ctrl[31:0], 32'h0);
        @(posedge clk); #1;
        check("mid_rst_pready_edge", 32'(bus.pready_o), 32'h0);
        bus.psel_i = 0; bus.penable_i = 0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_ctrl0", ctrl[31:0], 32'h0);
        check("post_rst_irq", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
